// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU interface: opcodes, sequencer states
// and default widths.
package alu_pkg;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned OPW   = 2;
  localparam int unsigned CNTW  = 8;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } seq_state_e;

endpackage

// File: rtl/alu_cmd_sequencer.sv
// Initiator for an external combinational 4-bit ALU: issues one host command at a
// time, captures result/carry, keeps an accumulator and a saturating carry count.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = alu_pkg::WIDTH,
  parameter int unsigned OPW   = alu_pkg::OPW,
  parameter int unsigned CNTW  = alu_pkg::CNTW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OPW-1:0]   cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_use_acc,
  input  logic             acc_clr,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic [WIDTH-1:0] acc,
  output logic [CNTW-1:0]  carry_cnt,
  output logic             busy
);

  localparam logic [CNTW-1:0] CNT_MAX = '1;

  seq_state_e       state, state_d;
  logic             accept_c;
  logic             capture_c;
  logic [WIDTH-1:0] acc_eff_c;

  // Ready is a pure state decode, forced low while reset is held.
  assign cmd_ready = (state == IDLE) && !rst;

  // A same-cycle clear hides the stale accumulator from the operand mux.
  assign acc_eff_c = acc_clr ? '0 : acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d   = state;
    accept_c  = 1'b0;
    capture_c = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          accept_c = 1'b1;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        capture_c = 1'b1;
        state_d   = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Status flags track the next state so they line up with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rsp_valid <= (state_d == RESP);
      busy      <= (state_d != IDLE);
    end
  end

  // ALU drive registers; held outside EXEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= '0;
    end else if (accept_c) begin
      alu_a  <= cmd_use_acc ? acc_eff_c : cmd_a;
      alu_b  <= cmd_b;
      alu_op <= cmd_op;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
    end else if (capture_c) begin
      rsp_result <= alu_result;
      rsp_carry  <= alu_carry;
    end
  end

  // Clear has priority over the EXEC capture for acc and the carry counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      carry_cnt <= '0;
    end else if (acc_clr) begin
      acc       <= '0;
      carry_cnt <= '0;
    end else if (capture_c) begin
      acc <= alu_result;
      if (alu_carry && (carry_cnt != CNT_MAX)) carry_cnt <= carry_cnt + CNTW'(1);
    end
  end

endmodule
